// File: rtl/grf_pkg.sv
// Shared register-file constants, also used by the hazard unit.
package grf_pkg;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam logic [GRF_ADDR_W-1:0] ZERO_REG = 5'd0;

    // True when a write to addr actually lands in the array.
    function automatic logic grf_commit(input logic reset, input logic we, input logic addr_nz);
        return !reset && we && addr_nz;
    endfunction

endpackage

// File: rtl/grf_read_port.sv
// One GRF read port: array read mux, same-cycle write bypass and pending lookup.
module grf_read_port
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NREG   = 2**ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_ra,
    input  logic [DATA_W-1:0] i_regs [NREG],
    input  logic [NREG-1:0]   i_pend,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd,
    output logic              o_rd_pend
);

    localparam logic BYP = (BYPASS != 0);

    logic w_ra_nz;
    logic w_hit;

    assign w_ra_nz = (i_ra != ADDR_W'(ZERO_REG));
    assign w_hit   = BYP && i_we && (i_wa == i_ra);

    // Read data: zero register, bypassed write data, or stored value.
    always_comb begin
        o_rd = {DATA_W{1'b0}};
        if (!w_ra_nz) begin
            o_rd = {DATA_W{1'b0}};
        end else if (w_hit && grf_commit(i_reset, i_we, 1'b1)) begin
            o_rd = i_wd;
        end else begin
            o_rd = i_regs[i_ra];
        end
    end

    // Hazard flag: a same-cycle writeback to this source resolves it.
    always_comb begin
        o_rd_pend = 1'b0;
        if (w_ra_nz && !w_hit) begin
            o_rd_pend = i_pend[i_ra];
        end else begin
            o_rd_pend = 1'b0;
        end
    end

endmodule

// File: rtl/grf_bypass_sb.sv
// General register file with write bypass and per-register pending scoreboard.
// Optional write trace enabled by defining GRF_TRACE_EN.
module grf_bypass_sb
    import grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_wa,
    input  logic [DATA_W-1:0]        i_wd,
    input  logic [31:0]              i_wpc,
    input  logic [NUM_RD*ADDR_W-1:0] i_ra,
    output logic [NUM_RD*DATA_W-1:0] o_rd,
    output logic [NUM_RD-1:0]        o_rd_pend,
    input  logic                     i_iss_valid,
    input  logic [ADDR_W-1:0]        i_iss_addr
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pend;
    logic              w_wa_nz;
    logic              w_commit;

    assign w_wa_nz  = (i_wa != ADDR_W'(ZERO_REG));
    assign w_commit = grf_commit(i_reset, i_we, w_wa_nz);

    // Register array; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int n = 0; n < NREG; n++) begin
                r_regs[n] <= {DATA_W{1'b0}};
            end
        end else if (w_commit) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Scoreboard: an issue to n re-arms the bit even if n writes back this cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend <= {NREG{1'b0}};
        end else begin
            for (int n = 1; n < NREG; n++) begin
                if (i_iss_valid && (i_iss_addr == ADDR_W'(n))) begin
                    r_pend[n] <= 1'b1;
                end else if (i_we && (i_wa == ADDR_W'(n))) begin
                    r_pend[n] <= 1'b0;
                end
            end
            r_pend[0] <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            grf_read_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NREG   (NREG),
                .BYPASS (BYPASS)
            ) u_port (
                .i_reset   (i_reset),
                .i_ra      (i_ra[gi*ADDR_W +: ADDR_W]),
                .i_regs    (r_regs),
                .i_pend    (r_pend),
                .i_we      (i_we),
                .i_wa      (i_wa),
                .i_wd      (i_wd),
                .o_rd      (o_rd[gi*DATA_W +: DATA_W]),
                .o_rd_pend (o_rd_pend[gi])
            );
        end
    endgenerate

`ifdef GRF_TRACE_EN
    // Commit trace for the instruction-level log.
    always @(posedge i_clk) begin
        if (w_commit) begin
            $display("@%h: $%d <= %h", i_wpc, i_wa, i_wd);
        end
    end
`else
    logic w_unused_wpc;
    assign w_unused_wpc = ^i_wpc;
`endif

endmodule

// File: tb/tb_grf_bypass_sb.sv
// Directed bench for grf_bypass_sb: one BYPASS=1 and one BYPASS=0 instance on shared inputs.
module tb_grf_bypass_sb;

    logic        clk = 1'b0;
    logic        reset, we, iss_valid;
    logic [4:0]  wa, iss_addr, ra0, ra1;
    logic [31:0] wd, wpc;
    logic [9:0]  ra;
    logic [63:0] rd_b, rd_n;
    logic [1:0]  pend_b, pend_n;

    int n_checks = 0;
    int n_fail   = 0;

    assign ra = {ra1, ra0};

    always #5 clk = ~clk;

    grf_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_we(we), .i_wa(wa), .i_wd(wd), .i_wpc(wpc),
        .i_ra(ra), .o_rd(rd_b), .o_rd_pend(pend_b),
        .i_iss_valid(iss_valid), .i_iss_addr(iss_addr)
    );

    grf_bypass_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_dut_n (
        .i_clk(clk), .i_reset(reset), .i_we(we), .i_wa(wa), .i_wd(wd), .i_wpc(wpc),
        .i_ra(ra), .o_rd(rd_n), .o_rd_pend(pend_n),
        .i_iss_valid(iss_valid), .i_iss_addr(iss_addr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wa = 5'd0; wd = 32'd0; iss_valid = 1'b0; iss_addr = 5'd0; reset = 1'b0;
    endtask

    initial begin
        wpc = 32'h0000_1000;
        ra0 = 5'd0; ra1 = 5'd0;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 1: everything cleared after reset
        for (int r = 0; r < 32; r++) begin
            ra0 = 5'(r); ra1 = 5'(r);
            #1;
            check_val("rst_rd0", rd_b[31:0], 32'd0);
            check_val("rst_rd1", rd_b[63:32], 32'd0);
            check_val("rst_pend", {30'd0, pend_b}, 32'd0);
        end

        // 2: bypass of same-cycle write
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra0 = 5'd5; ra1 = 5'd0;
        #2;
        check_val("byp_rd0", rd_b[31:0], 32'hDEAD_BEEF);
        check_val("nobyp_rd0", rd_n[31:0], 32'd0);
        tick();
        idle();
        #2;
        check_val("byp_rd0_next", rd_b[31:0], 32'hDEAD_BEEF);
        check_val("nobyp_rd0_next", rd_n[31:0], 32'hDEAD_BEEF);

        // 3: writes to register 0 discarded
        we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; ra0 = 5'd0;
        #2;
        check_val("r0_byp", rd_b[31:0], 32'd0);
        tick();
        idle();
        #2;
        check_val("r0_after", rd_b[31:0], 32'd0);
        check_val("r0_after_n", rd_n[31:0], 32'd0);

        // 4: issue sets pending, writeback clears it
        iss_valid = 1'b1; iss_addr = 5'd7; ra1 = 5'd7;
        #2;
        check_val("iss_pre", {31'd0, pend_b[1]}, 32'd0);
        tick();
        idle();
        #2;
        check_val("iss_pend_b", {31'd0, pend_b[1]}, 32'd1);
        check_val("iss_pend_n", {31'd0, pend_n[1]}, 32'd1);
        we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        #2;
        check_val("wb_pend_b", {31'd0, pend_b[1]}, 32'd0);
        check_val("wb_pend_n", {31'd0, pend_n[1]}, 32'd1);
        check_val("wb_rd1_b", rd_b[63:32], 32'h0000_0077);
        tick();
        idle();
        #2;
        check_val("wb_clr_b", {31'd0, pend_b[1]}, 32'd0);
        check_val("wb_clr_n", {31'd0, pend_n[1]}, 32'd0);
        check_val("wb_rd1_n", rd_n[63:32], 32'h0000_0077);

        // pending is a single bit: two issues, one writeback
        iss_valid = 1'b1; iss_addr = 5'd8;
        tick();
        tick();
        idle();
        ra0 = 5'd8; ra1 = 5'd8;
        #2;
        check_val("dbl_pend0", {30'd0, pend_b}, 32'd3);
        we = 1'b1; wa = 5'd8; wd = 32'h0000_0088;
        tick();
        idle();
        #2;
        check_val("dbl_clr", {30'd0, pend_b}, 32'd0);
        check_val("same_addr", rd_b[63:32], rd_b[31:0] == 32'h0000_0088 ? 32'h0000_0088 : 32'hFFFF_FFFF);

        // 5: simultaneous issue and writeback to 9: set wins, data written
        iss_valid = 1'b1; iss_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h0000_0099;
        ra0 = 5'd9; ra1 = 5'd0;
        tick();
        idle();
        #2;
        check_val("sim_pend", {31'd0, pend_b[0]}, 32'd1);
        check_val("sim_data", rd_b[31:0], 32'h0000_0099);
        check_val("sim_data_n", rd_n[31:0], 32'h0000_0099);

        // boundary: top register
        we = 1'b1; wa = 5'd31; wd = 32'hFFFF_FFFF; ra1 = 5'd31;
        tick();
        idle();
        #2;
        check_val("r31", rd_b[63:32], 32'hFFFF_FFFF);

        // 6: reset beats a write and an issue in the same cycle
        we = 1'b1; wa = 5'd3; wd = 32'h0000_A5A5; iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        ra0 = 5'd3; ra1 = 5'd5;
        #2;
        check_val("pre_rst_pend", {31'd0, pend_b[0]}, 32'd1);
        check_val("pre_rst_rd", rd_b[31:0], 32'h0000_A5A5);
        reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'd1; iss_valid = 1'b1; iss_addr = 5'd3;
        #2;
        check_val("in_rst_rd_b", rd_b[31:0], 32'h0000_A5A5);
        check_val("in_rst_pend_b", {31'd0, pend_b[0]}, 32'd0);
        check_val("in_rst_pend_n", {31'd0, pend_n[0]}, 32'd1);
        tick();
        idle();
        #2;
        check_val("post_rst_rd", rd_b[31:0], 32'd0);
        check_val("post_rst_pend", {31'd0, pend_b[0]}, 32'd0);
        check_val("post_rst_r5", rd_b[63:32], 32'd0);
        check_val("post_rst_r5_n", rd_n[63:32], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
